// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width and
// the bit-counter sizing helper.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } sub_state_e;

    // Counter must be able to count up to WIDTH without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built only from two-input NAND gates:
// DIFF = IN0 ^ IN1 ^ BIN, BOUT = (~IN0 & IN1) | (~(IN0 ^ IN1) & BIN).
module serial_subtractor_full_subtractor (
    input  logic IN0,
    input  logic IN1,
    input  logic BIN,
    output logic DIFF,
    output logic BOUT
);

    logic n_ab;
    logic n_a;
    logic n_b;
    logic x_ab;
    logic m_xb;
    logic m_x;
    logic m_b;
    logic inv_a;
    logic inv_x;
    logic t_ab;
    logic t_xb;

    // x_ab = IN0 ^ IN1
    nand g_n_ab (n_ab, IN0, IN1);
    nand g_n_a  (n_a, IN0, n_ab);
    nand g_n_b  (n_b, IN1, n_ab);
    nand g_x_ab (x_ab, n_a, n_b);

    // DIFF = x_ab ^ BIN
    nand g_m_xb (m_xb, x_ab, BIN);
    nand g_m_x  (m_x, x_ab, m_xb);
    nand g_m_b  (m_b, BIN, m_xb);
    nand g_diff (DIFF, m_x, m_b);

    // BOUT as a NAND of two NAND product terms
    nand g_inv_a (inv_a, IN0, IN0);
    nand g_inv_x (inv_x, x_ab, x_ab);
    nand g_t_ab  (t_ab, inv_a, IN1);
    nand g_t_xb  (t_xb, inv_x, BIN);
    nand g_bout  (BOUT, t_ab, t_xb);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B subtractor, LSB first, one bit per cycle over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output OVF.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    sub_state_e state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             bin_q, bin_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_diff;
    logic bit_bout;

    serial_subtractor_full_subtractor u_cell (
        .IN0  (a_sr_q[0]),
        .IN1  (b_sr_q[0]),
        .BIN  (bin_q),
        .DIFF (bit_diff),
        .BOUT (bit_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            StIdle: begin
                if (START) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = {bit_diff, res_sr_q[WIDTH-1:1]};
                bin_d    = bit_bout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Last bit: the cell sees the operand MSBs, so publish everything now.
                    state_d  = StDone;
                    diff_d   = {bit_diff, res_sr_q[WIDTH-1:1]};
                    borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_sr_q[0] ^ b_sr_q[0]) & (bit_diff ^ a_sr_q[0]);
`endif
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

    assign BUSY   = (state_q == StRun);
    assign DONE   = (state_q == StDone);
    assign DIFF   = diff_q;
    assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    logic       CLK;
    logic       RESET_N;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] DIFF;
    logic       BORROW;

    logic       START4;
    logic [3:0] A4;
    logic [3:0] B4;
    logic       BUSY4;
    logic       DONE4;
    logic [3:0] DIFF4;
    logic       BORROW4;

`ifdef SERIAL_SUB_OVF_EN
    logic       OVF;
    logic       OVF4;
`endif

    int n_cmp;
    int n_fail;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .A       (A),
        .B       (B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DIFF    (DIFF),
        .BORROW  (BORROW)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .OVF     (OVF)
`endif
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START4),
        .A       (A4),
        .B       (B4),
        .BUSY    (BUSY4),
        .DONE    (DONE4),
        .DIFF    (DIFF4),
        .BORROW  (BORROW4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .OVF     (OVF4)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one WIDTH=8 operation, scramble operands after capture, wait for DONE.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge CLK);
        START = 1'b1;
        A = a;
        B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 8'hAA;
        B = 8'h55;
        chk("busy_after_capture", 32'(BUSY), 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (DONE) break;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge CLK);
        START4 = 1'b1;
        A4 = a;
        B4 = b;
        @(posedge CLK);
        #1;
        START4 = 1'b0;
        A4 = ~a;
        B4 = ~b;
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (DONE4) break;
        end
    endtask

    initial begin
        int lat;
        int ndone;

        n_cmp   = 0;
        n_fail  = 0;
        RESET_N = 1'b1;
        START   = 1'b0;
        A       = '0;
        B       = '0;
        START4  = 1'b0;
        A4      = '0;
        B4      = '0;

        // Reset state
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_diff", 32'(DIFF), 32'd0);
        chk("rst_borrow", 32'(BORROW), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(OVF), 32'd0);
`endif
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // 0x35 - 0x12
        run8(8'h35, 8'h12, lat);
        chk("basic_latency", 32'(lat), 32'd8);
        chk("basic_diff", 32'(DIFF), 32'h23);
        chk("basic_borrow", 32'(BORROW), 32'd0);
        chk("basic_busy_in_done", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("basic_done_one_cycle", 32'(DONE), 32'd0);
        chk("basic_diff_held", 32'(DIFF), 32'h23);

        // 0x00 - 0x01: wraps with borrow
        run8(8'h00, 8'h01, lat);
        chk("wrap_latency", 32'(lat), 32'd8);
        chk("wrap_diff", 32'(DIFF), 32'hFF);
        chk("wrap_borrow", 32'(BORROW), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("wrap_ovf", 32'(OVF), 32'd0);
`endif
        repeat (3) @(negedge CLK);
        chk("wrap_diff_held_idle", 32'(DIFF), 32'hFF);
        chk("wrap_borrow_held_idle", 32'(BORROW), 32'd1);

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge CLK);
        START = 1'b1;
        A = 8'h55;
        B = 8'h11;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("abort_busy_before", 32'(BUSY), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_diff", 32'(DIFF), 32'd0);
        chk("abort_borrow", 32'(BORROW), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_idle_busy", 32'(BUSY), 32'd0);

        run8(8'h09, 8'h09, lat);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_diff", 32'(DIFF), 32'h00);
        chk("post_rst_borrow", 32'(BORROW), 32'd0);

        // 0x80 - 0x01: signed overflow, no borrow
        run8(8'h80, 8'h01, lat);
        chk("ovf_latency", 32'(lat), 32'd8);
        chk("ovf_diff", 32'(DIFF), 32'h7F);
        chk("ovf_borrow", 32'(BORROW), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_flag", 32'(OVF), 32'd1);
`endif

        // START held high; operands changed after capture
        @(negedge CLK);
        START = 1'b1;
        A = 8'h10;
        B = 8'h01;
        @(posedge CLK);
        #1;
        A = 8'hFF;
        B = 8'hFF;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (DONE) break;
        end
        chk("held_first_latency", 32'(lat), 32'd8);
        chk("held_first_diff", 32'(DIFF), 32'h0F);
        chk("held_first_borrow", 32'(BORROW), 32'd0);
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (DONE) break;
        end
        chk("held_period", 32'(lat), 32'd10);
        chk("held_second_diff", 32'(DIFF), 32'h00);
        chk("held_second_borrow", 32'(BORROW), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        chk("held_release_done", 32'(DONE), 32'd0);
        chk("held_release_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("held_no_recapture", 32'(BUSY), 32'd0);

        // Exhaustive WIDTH=4 sweep against A-B reference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int exp_d;
                int exp_ovf;
                exp_d = (ia - ib) & 15;
                run4(4'(ia), 4'(ib), lat);
                chk("sweep_latency", 32'(lat), 32'd4);
                chk("sweep_diff", 32'(DIFF4), 32'(exp_d));
                chk("sweep_borrow", 32'(BORROW4), (ia < ib) ? 32'd1 : 32'd0);
                chk("sweep_busy_in_done", 32'(BUSY4), 32'd0);
                exp_ovf = (((ia >> 3) ^ (ib >> 3)) & ((exp_d >> 3) ^ (ia >> 3))) & 1;
`ifdef SERIAL_SUB_OVF_EN
                chk("sweep_ovf", 32'(OVF4), 32'(exp_ovf));
`else
                if (exp_ovf > 1) $display("unreachable");
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request to begin one subtraction.
REQ-005 SHALL have port A  input  WIDTH  minuend, sampled only when START is accepted.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, sampled only when START is accepted.
REQ-007 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port DIFF  output  WIDTH  result A-B modulo 2^WIDTH.
REQ-010 SHALL have port BORROW  output  1  final borrow-out, high when unsigned A < B.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: START=1 sampled at edge k SHALL capture A, B, clear the borrow flop and bit counter, and enter RUN; BUSY=1 from edge k.
REQ-013 RUN SHALL process exactly one bit per cycle, LSB first, over WIDTH cycles (edges k+1..k+WIDTH).
REQ-014 Each bit: d = a XOR b XOR bin; bout = (~a & b) | (~(a XOR b) & bin); bin for bit 0 SHALL be 0.
REQ-015 Edge k+WIDTH SHALL enter DONE with DIFF and BORROW final; DONE=1 and BUSY=0 for exactly that one cycle.
REQ-016 DONE SHALL return to IDLE unconditionally on the next edge; START is ignored in DONE.
REQ-017 Latency from START acceptance to DONE pulse SHALL be WIDTH cycles; throughput one result per WIDTH+2 cycles.
REQ-018 START asserted during RUN or DONE SHALL be ignored; A/B changes after capture SHALL have no effect.
REQ-019 DIFF and BORROW SHALL hold their last final values through IDLE until the next DONE; DIFF need not be valid during RUN.
REQ-020 Bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-021 RESET_N low SHALL immediately force state IDLE, BUSY=0, DONE=0, DIFF=0, BORROW=0, counter and borrow flop 0.
REQ-022 Reset during RUN SHALL abort the operation with no DONE pulse; the first START after RESET_N rises SHALL be processed normally.

Configuration
REQ-023 Macro SERIAL_SUB_OVF_EN defined SHALL add output OVF (1 bit): signed two's-complement overflow, = (A[msb] XOR B[msb]) AND (DIFF[msb] XOR A[msb]), registered with DIFF, reset 0, held like DIFF.
REQ-024 Macro undefined SHALL omit the OVF port and its logic; all other behaviour identical.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH constant.
REQ-026 Single bit-cell sub-module FULL_SUBTRACTOR (ports DIFF, BOUT, IN0, IN1, BIN) SHALL compute REQ-014 combinationally, built from NAND primitives; instantiated once.
REQ-027 Datapath SHALL be A and B shift registers, result shift register, one borrow flop, counter.

Verification
REQ-028 WIDTH=8, A=0x35, B=0x12, START one cycle -> DONE exactly 8 cycles later, DIFF=0x23, BORROW=0.
REQ-029 A=0x00, B=0x01 -> DIFF=0xFF, BORROW=1; with SERIAL_SUB_OVF_EN, OVF=0.
REQ-030 With SERIAL_SUB_OVF_EN, A=0x80, B=0x01 -> DIFF=0x7F, BORROW=0, OVF=1.
REQ-031 START held high continuously with A=0x10, B=0x01, operands changed to 0xFF/0xFF after capture -> DIFF=0x0F, one DONE per WIDTH+2 cycles, no extra captures.
REQ-032 RESET_N low at 4th RUN cycle -> BUSY, DONE, DIFF, BORROW all 0 immediately, no DONE pulse; next START A=0x09, B=0x09 -> DIFF=0x00, BORROW=0.
REQ-033 Exhaustive sweep at WIDTH=4: all 256 A/B pairs compared against reference A-B model for DIFF and BORROW.
